// File: rtl/csr_counter_wr.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter_wr
// Brief    : Atomic RW/RS/RC access unit for mcycle, minstret and mcountinhibit.
// Revision : 1.0 - initial release
// ============================================================================
module csr_counter_wr #(
    parameter int               XLEN              = 32,
    parameter logic [XLEN-1:0]  MCOUNTINHIBIT_RST = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            retire,
    input  wire logic            stall,
    input  wire logic            req_valid,
    output logic                 req_ready,
    input  wire logic [11:0]     req_addr,
    input  wire logic [1:0]      req_op,
    input  wire logic [XLEN-1:0] req_wdata,
    output logic                 resp_valid,
    input  wire logic            resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_illegal
);

    localparam logic [1:0]      c_OP_RW    = 2'b01;
    localparam logic [1:0]      c_OP_RS    = 2'b10;
    localparam logic [1:0]      c_OP_RC    = 2'b11;
    localparam logic [11:0]     c_A_CYC_LO = 12'hB00;
    localparam logic [11:0]     c_A_CYC_HI = 12'hB80;
    localparam logic [11:0]     c_A_IRT_LO = 12'hB02;
    localparam logic [11:0]     c_A_IRT_HI = 12'hB82;
    localparam logic [11:0]     c_A_INH    = 12'h320;
    localparam logic [XLEN-1:0] c_INH_MASK = {{(XLEN-3){1'b0}}, 3'b101};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t             r_state;
    logic [2*XLEN-1:0]  r_mcycle;
    logic [2*XLEN-1:0]  r_minstret;
    logic [XLEN-1:0]    r_inhibit;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic [XLEN-1:0]    r_rdata;
    logic               r_illegal;

    logic               w_ro;
    logic [11:0]        w_base;
    logic               w_hit;
    logic [4:0]         w_sel;
    logic [XLEN-1:0]    w_old;
    logic [XLEN-1:0]    w_new;
    logic               w_wr;
    logic               w_illegal;
    logic               w_accept;
    logic               w_commit;
    logic               w_cy_inc;
    logic               w_ir_inc;
    logic [2*XLEN-1:0]  w_mcycle_nxt;
    logic [2*XLEN-1:0]  w_minstret_nxt;
    logic [XLEN-1:0]    w_cyc_lo_sum;
    logic [XLEN-1:0]    w_irt_lo_sum;

    // C-range addresses alias the B-range counters as read-only shadows
    assign w_ro   = (req_addr[11:8] == 4'hC);
    assign w_base = w_ro ? {4'hB, req_addr[7:0]} : req_addr;

    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        w_old = '0;
        case (w_base)
            c_A_CYC_LO: begin w_hit = 1'b1; w_sel[0] = 1'b1; w_old = r_mcycle[XLEN-1:0];        end
            c_A_CYC_HI: begin w_hit = 1'b1; w_sel[1] = 1'b1; w_old = r_mcycle[2*XLEN-1:XLEN];   end
            c_A_IRT_LO: begin w_hit = 1'b1; w_sel[2] = 1'b1; w_old = r_minstret[XLEN-1:0];      end
            c_A_IRT_HI: begin w_hit = 1'b1; w_sel[3] = 1'b1; w_old = r_minstret[2*XLEN-1:XLEN]; end
            c_A_INH:    begin w_hit = 1'b1; w_sel[4] = 1'b1; w_old = r_inhibit;                 end
            default:    begin w_hit = 1'b0; end
        endcase
    end

    always_comb begin
        case (req_op)
            c_OP_RW: w_new = req_wdata;
            c_OP_RS: w_new = w_old | req_wdata;
            c_OP_RC: w_new = w_old & ~req_wdata;
            default: w_new = w_old;
        endcase
    end

    assign w_wr      = (req_op == c_OP_RW) || ((req_op != 2'b00) && (req_wdata != '0));
    assign w_illegal = (req_op == 2'b00) || !w_hit || (w_ro && w_wr);
    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_commit  = w_accept && !w_illegal && w_wr;

    assign w_cy_inc     = !r_inhibit[0];
    assign w_ir_inc     = retire && !stall && !r_inhibit[2];
    assign w_cyc_lo_sum = r_mcycle[XLEN-1:0]   + {{(XLEN-1){1'b0}}, w_cy_inc};
    assign w_irt_lo_sum = r_minstret[XLEN-1:0] + {{(XLEN-1){1'b0}}, w_ir_inc};

    // A high-half write still lets the low half count, but its carry is dropped
    always_comb begin
        w_mcycle_nxt   = r_mcycle   + {{(2*XLEN-1){1'b0}}, w_cy_inc};
        w_minstret_nxt = r_minstret + {{(2*XLEN-1){1'b0}}, w_ir_inc};
        if (w_commit && w_sel[0]) w_mcycle_nxt   = {r_mcycle[2*XLEN-1:XLEN], w_new};
        if (w_commit && w_sel[1]) w_mcycle_nxt   = {w_new, w_cyc_lo_sum};
        if (w_commit && w_sel[2]) w_minstret_nxt = {r_minstret[2*XLEN-1:XLEN], w_new};
        if (w_commit && w_sel[3]) w_minstret_nxt = {w_new, w_irt_lo_sum};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mcycle     <= '0;
            r_minstret   <= '0;
            r_inhibit    <= MCOUNTINHIBIT_RST & c_INH_MASK;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_mcycle   <= w_mcycle_nxt;
            r_minstret <= w_minstret_nxt;
            if (w_commit && w_sel[4]) begin
                r_inhibit <= w_new & c_INH_MASK;
            end
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state      <= S_RESP;
                        r_req_ready  <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_illegal ? '0 : w_old;
                        r_illegal    <= w_illegal;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_rdata;
    assign resp_illegal = r_illegal;

endmodule
`default_nettype wire
